// File: rtl/pipe_stall_ctrl.sv
// Purpose : pipeline stall controller for a multi-cycle divider and load-use hazards.
// Latency : all outputs are combinational from state and inputs (zero cycles);
//           stall_cycles is registered and updates one clock after the stall.
// Backpressure: stall[3:0] stops PC/IF/ID/EX; MEM and WB are never stopped.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   id_load_use       ID sees a load-use hazard against the load in EX
//   ex_div_req        EX holds div/divu
//   ex_div_src_zero   an operand of the div in EX is zero (early-exit build only)
//   stall[5:0]        per-stage stop: {WB, MEM, EX, ID, IF, PC}, 1 = stop
//   div_start         one-cycle pulse that loads the divider operands
//   div_busy          divider iterating; HI/LO writes are blocked
//   div_done          one-cycle pulse; HI/LO latch the divider result
//   stall_cycles      free-running count of cycles with any stall bit set
//
// Build option: define DIV_EARLY_EXIT_EN to let a div with a zero operand
// skip the iteration phase and finish in the cycle after issue.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_load_use,
    input  logic        ex_div_req,
    input  logic        ex_div_src_zero,
    output logic [5:0]  stall,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    // A div holds everything up to and including EX.
    localparam logic [5:0] STALL_DIV = 6'b001111;
    // A load-use hazard holds PC/IF/ID and lets EX take a bubble.
    localparam logic [5:0] STALL_LU  = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

`ifndef DIV_EARLY_EXIT_EN
    // Operand-zero information has no use without the early-exit path.
    logic unused_src_zero;
    assign unused_src_zero = ex_div_src_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are forced low while rst is high so that nothing downstream
    // sees a start/done pulse during reset, whatever the inputs are doing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 6'b000000;
        div_start = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    // The div takes priority over a simultaneous load-use.
                    if (ex_div_req) begin
                        div_start = 1'b1;
                        stall     = STALL_DIV;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
`ifdef DIV_EARLY_EXIT_EN
                        if (ex_div_src_zero) begin
                            state_nxt = DONE;
                        end
`endif
                    end else if (id_load_use) begin
                        stall = STALL_LU;
                    end
                end

                RUN: begin
                    // id_load_use is masked here: the div pattern already
                    // covers every stage the hazard would stop.
                    stall    = STALL_DIV;
                    div_busy = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = DONE;
                    end
                end

                DONE: begin
                    // EX is released into MEM this cycle; the request line is
                    // still high from the same div, so it must not restart.
                    div_done  = 1'b1;
                    state_nxt = IDLE;
                    if (id_load_use) begin
                        stall = STALL_LU;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (stall != 6'b000000) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
